// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module  : sync_fifo_pkg
// Brief   : Shared types and sizing helper for the single-clock FIFO controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  localparam fifo_flags_t C_FLAGS_RST = '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};

  // Occupancy width must hold the value DEPTH itself, hence depth+1.
  function automatic int fifo_cnt_wd(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ptr_ctr.sv
// ============================================================================
// Module  : fifo_ptr_ctr
// Brief   : Modulo-DEPTH address counter with sync reset, flush and increment.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ptr_ctr #(
  parameter int DEPTH  = 1024,
  parameter int PTR_WD = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [PTR_WD-1:0] ptr_o
);

  localparam logic [PTR_WD-1:0] C_LAST = PTR_WD'(DEPTH - 1);

  logic [PTR_WD-1:0] r_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_ptr <= '0;
    end else if (inc_i) begin
      // Explicit wrap so non-power-of-2 depths never address past DEPTH-1.
      r_ptr <= (r_ptr == C_LAST) ? '0 : r_ptr + PTR_WD'(1);
    end
  end

  assign ptr_o = r_ptr;

endmodule

`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
// ============================================================================
// Module  : sync_fifo_ctrl
// Brief   : Single-clock FIFO pointer/flag controller driving an external SDP RAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int PTR_WD = $clog2(DEPTH),
  parameter int CNT_WD = fifo_cnt_wd(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              w_en_i,
  input  logic              r_en_i,
  input  logic              err_clr_i,
  input  logic [CNT_WD-1:0] afull_thr_i,
  input  logic [CNT_WD-1:0] aempty_thr_i,
  output logic              w_we_o,
  output logic [PTR_WD-1:0] w_addr_o,
  output logic              r_re_o,
  output logic [PTR_WD-1:0] r_addr_o,
  output logic [CNT_WD-1:0] data_cnt_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              afull_o,
  output logic              aempty_o,
  output logic              ovf_o,
  output logic              udf_o
);

  localparam logic [CNT_WD-1:0] C_DEPTH = CNT_WD'(DEPTH);

  logic              w_wacc;
  logic              w_racc;
  logic              w_ovf_set;
  logic              w_udf_set;
  logic [CNT_WD-1:0] w_cnt_nxt;
  fifo_flags_t       w_flags_nxt;

  logic [CNT_WD-1:0] r_cnt;
  fifo_flags_t       r_flags;
  logic              r_ovf;
  logic              r_udf;

  always_comb begin
    w_wacc    = w_en_i & ~r_flags.full  & ~clr_i;
    w_racc    = r_en_i & ~r_flags.empty & ~clr_i;
    w_ovf_set = w_en_i &  r_flags.full  & ~clr_i;
    w_udf_set = r_en_i &  r_flags.empty & ~clr_i;

    if (clr_i) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + CNT_WD'(w_wacc) - CNT_WD'(w_racc);
    end

    // Flags come from the next count so they line up with data_cnt_o.
    w_flags_nxt.full   = (w_cnt_nxt == C_DEPTH);
    w_flags_nxt.empty  = (w_cnt_nxt == '0);
    w_flags_nxt.afull  = (w_cnt_nxt >= afull_thr_i);
    w_flags_nxt.aempty = (w_cnt_nxt <= aempty_thr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_flags <= C_FLAGS_RST;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_flags <= w_flags_nxt;
      r_ovf   <= w_ovf_set | (r_ovf & ~err_clr_i);
      r_udf   <= w_udf_set | (r_udf & ~err_clr_i);
    end
  end

  fifo_ptr_ctr #(
    .DEPTH  (DEPTH),
    .PTR_WD (PTR_WD)
  ) u_wr_ptr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (clr_i),
    .inc_i  (w_wacc),
    .ptr_o  (w_addr_o)
  );

  fifo_ptr_ctr #(
    .DEPTH  (DEPTH),
    .PTR_WD (PTR_WD)
  ) u_rd_ptr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (clr_i),
    .inc_i  (w_racc),
    .ptr_o  (r_addr_o)
  );

  assign w_we_o     = w_wacc;
  assign r_re_o     = w_racc;
  assign data_cnt_o = r_cnt;
  assign full_o     = r_flags.full;
  assign empty_o    = r_flags.empty;
  assign afull_o    = r_flags.afull;
  assign aempty_o   = r_flags.aempty;
  assign ovf_o      = r_ovf;
  assign udf_o      = r_udf;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
// ============================================================================
// Module  : tb_sync_fifo_ctrl
// Brief   : Scoreboard bench for sync_fifo_ctrl at DEPTH=6.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_ctrl;

  localparam int DEPTH  = 6;
  localparam int PTR_WD = 3;
  localparam int CNT_WD = 3;

  typedef struct packed {
    logic [2:0] waddr;
    logic [2:0] raddr;
    logic [2:0] cnt;
    logic full, empty, afull, aempty, ovf, udf;
  } st_t;

  typedef struct packed {
    logic [1:0] s;
    st_t        st;
  } exp_t;

  localparam st_t RST_ST = '{waddr: 3'd0, raddr: 3'd0, cnt: 3'd0, full: 1'b0, empty: 1'b1,
                             afull: 1'b0, aempty: 1'b1, ovf: 1'b0, udf: 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b0, clr = 1'b0, w_en = 1'b0, r_en = 1'b0, err_clr = 1'b0;
  logic [CNT_WD-1:0] afull_thr = 3'd5, aempty_thr = 3'd1;
  logic w_we, r_re, full, empty, afull, aempty, ovf, udf;
  logic [PTR_WD-1:0] w_addr, r_addr;
  logic [CNT_WD-1:0] data_cnt;

  st_t        m = RST_ST;
  exp_t       exp_q[$];
  exp_t       e;
  logic [1:0] obs_strb;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.DEPTH(DEPTH), .PTR_WD(PTR_WD), .CNT_WD(CNT_WD)) dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .w_en_i(w_en), .r_en_i(r_en),
    .err_clr_i(err_clr), .afull_thr_i(afull_thr), .aempty_thr_i(aempty_thr),
    .w_we_o(w_we), .w_addr_o(w_addr), .r_re_o(r_re), .r_addr_o(r_addr),
    .data_cnt_o(data_cnt), .full_o(full), .empty_o(empty), .afull_o(afull),
    .aempty_o(aempty), .ovf_o(ovf), .udf_o(udf)
  );

  function automatic st_t cur_st();
    return st_t'({w_addr, r_addr, data_cnt, full, empty, afull, aempty, ovf, udf});
  endfunction

  // Drive one cycle, sample strobes before the edge, push the model's expectation.
  task automatic apply(input logic w, input logic r, input logic c, input logic ec, input logic rs);
    exp_t x;
    logic wa, ra;
    w_en = w; r_en = r; clr = c; err_clr = ec; rst = rs;
    #1;
    obs_strb = {w_we, r_re};
    wa = w & ~m.full & ~c;
    ra = r & ~m.empty & ~c;
    x.s = {wa, ra};
    if (rs) begin
      m = RST_ST;
    end else begin
      m.ovf = (w & m.full & ~c) | (m.ovf & ~ec);
      m.udf = (r & m.empty & ~c) | (m.udf & ~ec);
      if (c) begin
        m.cnt = 3'd0; m.waddr = 3'd0; m.raddr = 3'd0;
      end else begin
        m.cnt = 3'(int'(m.cnt) + int'(wa) - int'(ra));
        if (wa) m.waddr = (m.waddr == 3'd5) ? 3'd0 : m.waddr + 3'd1;
        if (ra) m.raddr = (m.raddr == 3'd5) ? 3'd0 : m.raddr + 3'd1;
      end
      m.full   = (m.cnt == 3'd6);
      m.empty  = (m.cnt == 3'd0);
      m.afull  = (m.cnt >= afull_thr);
      m.aempty = (m.cnt <= aempty_thr);
    end
    x.st = m;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 0, 0, 1);
      e = exp_q.pop_front(); n_chk++;
      if ({obs_strb, cur_st()} !== {e.s, e.st})
        $display("FAIL reset step%0d got=%h exp=%h", i, {obs_strb, cur_st()}, {e.s, e.st});
      else n_pass++;
    end
    n_chk++;
    if (cur_st() !== RST_ST) $display("FAIL reset_state got=%h exp=%h", cur_st(), RST_ST);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 7; i++) begin
      apply(1, 0, 0, 0, 0);
      e = exp_q.pop_front(); n_chk++;
      if ({obs_strb, cur_st()} !== {e.s, e.st})
        $display("FAIL fill step%0d got=%h exp=%h", i, {obs_strb, cur_st()}, {e.s, e.st});
      else n_pass++;
      if (i == 4) begin
        n_chk++;
        if (afull !== 1'b1 || full !== 1'b0) $display("FAIL fill_afull got=%b%b exp=10", afull, full);
        else n_pass++;
      end
    end
    n_chk++;
    if (obs_strb !== 2'b00 || cur_st() !== st_t'({3'd0, 3'd0, 3'd6, 6'b101010}))
      $display("FAIL fill_full got=%h exp=%h", {obs_strb, cur_st()}, {2'b00, 3'd0, 3'd0, 3'd6, 6'b101010});
    else n_pass++;
  endtask

  task automatic test_full_wr();
    apply(1, 1, 0, 0, 0);
    e = exp_q.pop_front(); n_chk++;
    if ({obs_strb, cur_st()} !== {e.s, e.st})
      $display("FAIL full_wr got=%h exp=%h", {obs_strb, cur_st()}, {e.s, e.st});
    else n_pass++;
    n_chk++;
    if (obs_strb !== 2'b01 || data_cnt !== 3'd5 || full !== 1'b0 || ovf !== 1'b1)
      $display("FAIL full_wr_const got=%b/%0d/%b/%b exp=01/5/0/1", obs_strb, data_cnt, full, ovf);
    else n_pass++;
    apply(0, 0, 0, 1, 0);
    e = exp_q.pop_front(); n_chk++;
    if ({obs_strb, cur_st()} !== {e.s, e.st} || ovf !== 1'b0)
      $display("FAIL err_clr got=%h exp=%h", {obs_strb, cur_st()}, {e.s, e.st});
    else n_pass++;
  endtask

  task automatic test_steady();
    for (int i = 0; i < 22; i++) begin
      if (i < 2) apply(0, 1, 0, 0, 0);
      else       apply(1, 1, 0, 0, 0);
      e = exp_q.pop_front(); n_chk++;
      if ({obs_strb, cur_st()} !== {e.s, e.st})
        $display("FAIL steady step%0d got=%h exp=%h", i, {obs_strb, cur_st()}, {e.s, e.st});
      else n_pass++;
    end
    n_chk++;
    if (data_cnt !== 3'd3 || {full, empty, afull, aempty} !== 4'b0000)
      $display("FAIL steady_cnt got=%0d/%b exp=3/0000", data_cnt, {full, empty, afull, aempty});
    else n_pass++;
  endtask

  task automatic test_empty();
    for (int i = 0; i < 5; i++) begin
      if (i < 4)       apply(0, 1, 0, 0, 0);
      else             apply(1, 1, 0, 0, 0);
      e = exp_q.pop_front(); n_chk++;
      if ({obs_strb, cur_st()} !== {e.s, e.st})
        $display("FAIL empty step%0d got=%h exp=%h", i, {obs_strb, cur_st()}, {e.s, e.st});
      else n_pass++;
      if (i == 3) begin
        n_chk++;
        if (udf !== 1'b1 || obs_strb !== 2'b00) $display("FAIL empty_udf got=%b/%b exp=1/00", udf, obs_strb);
        else n_pass++;
      end
    end
    n_chk++;
    if (obs_strb !== 2'b10 || data_cnt !== 3'd1 || empty !== 1'b0)
      $display("FAIL empty_wr got=%b/%0d/%b exp=10/1/0", obs_strb, data_cnt, empty);
    else n_pass++;
  endtask

  task automatic test_threshold();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) apply(1, 0, 0, 0, 0);
      else begin
        if (i == 1) begin afull_thr = 3'd0; aempty_thr = 3'd7; end
        else        begin afull_thr = 3'd5; aempty_thr = 3'd1; end
        apply(0, 0, 0, 0, 0);
      end
      e = exp_q.pop_front(); n_chk++;
      if ({obs_strb, cur_st()} !== {e.s, e.st})
        $display("FAIL thresh step%0d got=%h exp=%h", i, {obs_strb, cur_st()}, {e.s, e.st});
      else n_pass++;
      if (i == 1) begin
        n_chk++;
        if ({afull, aempty} !== 2'b11) $display("FAIL thresh_ext got=%b exp=11", {afull, aempty});
        else n_pass++;
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 8; i++) begin
      if (i < 5)      apply(1, 0, 0, 0, 0);
      else if (i < 7) apply(0, 1, 0, 0, 0);
      else            apply(1, 0, 1, 0, 0);
      e = exp_q.pop_front(); n_chk++;
      if ({obs_strb, cur_st()} !== {e.s, e.st})
        $display("FAIL flush step%0d got=%h exp=%h", i, {obs_strb, cur_st()}, {e.s, e.st});
      else n_pass++;
      if (i == 6) begin
        n_chk++;
        if (data_cnt !== 3'd4 || ovf !== 1'b1) $display("FAIL flush_pre got=%0d/%b exp=4/1", data_cnt, ovf);
        else n_pass++;
      end
    end
    n_chk++;
    if (obs_strb !== 2'b00 || w_addr !== 3'd0 || r_addr !== 3'd0 || data_cnt !== 3'd0 ||
        empty !== 1'b1 || full !== 1'b0 || ovf !== 1'b1)
      $display("FAIL flush_state got=%b/%0d/%0d/%0d/%b/%b/%b exp=00/0/0/0/1/0/1",
               obs_strb, w_addr, r_addr, data_cnt, empty, full, ovf);
    else n_pass++;
  endtask

  task automatic test_random_reset();
    int k;
    k = $urandom_range(10, 30);
    for (int i = 0; i < 40; i++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
            ($urandom_range(0, 15) == 0), (i == k));
      e = exp_q.pop_front(); n_chk++;
      if ({obs_strb, cur_st()} !== {e.s, e.st})
        $display("FAIL random step%0d got=%h exp=%h", i, {obs_strb, cur_st()}, {e.s, e.st});
      else n_pass++;
      if (i == k) begin
        n_chk++;
        if (cur_st() !== RST_ST) $display("FAIL midrst got=%h exp=%h", cur_st(), RST_ST);
        else n_pass++;
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_full_wr();
    test_steady();
    test_empty();
    test_threshold();
    test_flush();
    test_random_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
